piso_shifter: RTL and testbench

PISO_SHIFTER -- requirements
Module: piso_shifter

---
 rtl/piso_shifter_pkg.sv | 18 +
 rtl/piso_shifter_bit_timer.sv | 32 +++
 rtl/piso_shifter.sv | 123 ++++++++++++
 tb/tb_piso_shifter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/piso_shifter_pkg.sv
// Shared definitions for the serialiser lab blocks: FSM encodings, default
// sizing and the counter-width helper.
package piso_shifter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int N_DEFAULT   = 8;
  localparam int DIV_DEFAULT = 4;

  // Bits needed for a counter running 0..m-1, never narrower than one bit.
  function automatic int cnt_width(input int m);
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/piso_shifter_bit_timer.sv
// Bit-period timer: counts 0..DIV-1 while enabled, tick marks the count-0 cycle.
module bit_timer
  import piso_shifter_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int TW = cnt_width(DIV);
  localparam logic [TW-1:0] LAST = TW'(DIV - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == '0);

endmodule

// File: rtl/piso_shifter.sv
// Parallel-in serial-out shifter; every output is a flop loaded one cycle
// ahead, so the timer runs from the accept cycle and its tick marks the
// cycle before each new bit period.
//
//   state | meaning
//   IDLE  | ready for a word, serial outputs quiet
//   SHIFT | frame in flight, load ignored
module piso_shifter
  import piso_shifter_pkg::*;
#(
  parameter int N         = N_DEFAULT,
  parameter int DIV       = DIV_DEFAULT,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] din,
  output logic         ready,
  output logic         sout,
  output logic         sframe,
  output logic         bit_stb,
  output logic         done
);

  localparam int BW = cnt_width(N);
  localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

  state_t         state, state_d;
  logic [N-1:0]   sreg, sreg_d;
  logic [BW-1:0]  bcnt, bcnt_d;
  logic           ready_d, sout_d, sframe_d, stb_d, done_d;
  logic           tick, timer_en, timer_rst, frame_end;

  assign timer_en  = ((state == IDLE) && load) || (state == SHIFT);
  assign frame_end = (state == SHIFT) && tick && (bcnt == LAST_BIT);
  // Clearing the timer at frame end leaves it at 0 for a load in the done cycle.
  assign timer_rst = rst && !frame_end;

  bit_timer #(.DIV(DIV)) u_timer (
    .clk  (clk),
    .rst  (timer_rst),
    .en   (timer_en),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      sreg    <= '0;
      bcnt    <= '0;
      ready   <= 1'b1;
      sout    <= 1'b0;
      sframe  <= 1'b0;
      bit_stb <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      sreg    <= sreg_d;
      bcnt    <= bcnt_d;
      ready   <= ready_d;
      sout    <= sout_d;
      sframe  <= sframe_d;
      bit_stb <= stb_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d  = state;
    sreg_d   = sreg;
    bcnt_d   = bcnt;
    ready_d  = ready;
    sout_d   = sout;
    sframe_d = sframe;
    stb_d    = 1'b0;
    done_d   = 1'b0;
    case (state)
      IDLE: begin
        ready_d  = 1'b1;
        sout_d   = 1'b0;
        sframe_d = 1'b0;
        if (load) begin
          state_d  = SHIFT;
          bcnt_d   = '0;
          ready_d  = 1'b0;
          sframe_d = 1'b1;
          stb_d    = 1'b1;
          if (MSB_FIRST) begin
            sout_d = din[N-1];
            sreg_d = din << 1;
          end else begin
            sout_d = din[0];
            sreg_d = din >> 1;
          end
        end
      end
      SHIFT: begin
        if (frame_end) begin
          state_d  = IDLE;
          sreg_d   = '0;
          bcnt_d   = '0;
          ready_d  = 1'b1;
          sout_d   = 1'b0;
          sframe_d = 1'b0;
          done_d   = 1'b1;
        end else if (tick) begin
          bcnt_d = bcnt + 1'b1;
          stb_d  = 1'b1;
          if (MSB_FIRST) begin
            sout_d = sreg[N-1];
            sreg_d = sreg << 1;
          end else begin
            sout_d = sreg[0];
            sreg_d = sreg >> 1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso_shifter.sv
// Directed bench for piso_shifter: MSB/LSB-first 8-bit instances at DIV=4
// and a 4-bit DIV=1 instance.
module tb_piso_shifter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_m = 1'b0, load_l = 1'b0, load_4 = 1'b0;
  logic [7:0] din = '0;
  logic [3:0] din4 = '0;

  logic rdy_m, so_m, sf_m, stb_m, dn_m;
  logic rdy_l, so_l, sf_l, stb_l, dn_l;
  logic rdy_4, so_4, sf_4, stb_4, dn_4;

  // Observation vectors: {sout, sframe, bit_stb, done, ready}
  wire [4:0] vec_m = {so_m, sf_m, stb_m, dn_m, rdy_m};
  wire [4:0] vec_l = {so_l, sf_l, stb_l, dn_l, rdy_l};
  wire [4:0] vec_4 = {so_4, sf_4, stb_4, dn_4, rdy_4};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_shifter #(.N(8), .DIV(4), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .load(load_m), .din(din),
    .ready(rdy_m), .sout(so_m), .sframe(sf_m), .bit_stb(stb_m), .done(dn_m));

  piso_shifter #(.N(8), .DIV(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .load(load_l), .din(din),
    .ready(rdy_l), .sout(so_l), .sframe(sf_l), .bit_stb(stb_l), .done(dn_l));

  piso_shifter #(.N(4), .DIV(1), .MSB_FIRST(1'b1)) dut_4 (
    .clk(clk), .rst(rst), .load(load_4), .din(din4),
    .ready(rdy_4), .sout(so_4), .sframe(sf_4), .bit_stb(stb_4), .done(dn_4));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected vector for cycle c (1..33) of an 8-bit DIV=4 frame of word d.
  function automatic logic [4:0] exp8(input logic lsb, input logic [7:0] d, input int c);
    int   bi;
    logic b;
    if (c >= 33) return 5'b00011;
    bi = (c - 1) / 4;
    b  = lsb ? d[bi] : d[7 - bi];
    return {b, 1'b1, ((c - 1) % 4) == 0, 1'b0, 1'b0};
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    load_m = 1'b1;
    din = 8'hFF;
    step();
    step();
    checks++; if (vec_m !== 5'b00001) begin errors++; $display("FAIL reset_m got %b want %b", vec_m, 5'b00001); end
    checks++; if (vec_l !== 5'b00001) begin errors++; $display("FAIL reset_l got %b want %b", vec_l, 5'b00001); end
    checks++; if (vec_4 !== 5'b00001) begin errors++; $display("FAIL reset_4 got %b want %b", vec_4, 5'b00001); end
    load_m = 1'b0;
    rst = 1'b1;
    step();
    checks++; if (vec_m !== 5'b00001) begin errors++; $display("FAIL reset_release got %b want %b", vec_m, 5'b00001); end
  endtask

  task automatic check_frame8(input logic lsb, input logic [7:0] d, input logic pulses, input string name);
    logic [4:0] v, e;
    din = d;
    if (lsb) load_l = 1'b1; else load_m = 1'b1;
    v = lsb ? vec_l : vec_m;
    checks++; if (v[0] !== 1'b1) begin errors++; $display("FAIL %s ready_c0 got %b want 1", name, v[0]); end
    step();
    load_l = 1'b0;
    load_m = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      v = lsb ? vec_l : vec_m;
      e = exp8(lsb, d, c);
      checks++;
      if (v !== e) begin errors++; $display("FAIL %s cycle %0d got %b want %b", name, c, v, e); end
      if (pulses && (c == 3 || c == 20)) load_m = 1'b1; else load_m = 1'b0;
      step();
    end
    load_m = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [4:0] e;
    din = 8'hFF;
    load_m = 1'b1;
    step();
    for (int c = 1; c <= 66; c++) begin
      if (c <= 33)      e = exp8(1'b0, 8'hFF, c);
      else              e = exp8(1'b0, 8'h00, c - 33);
      checks++;
      if (vec_m !== e) begin errors++; $display("FAIL b2b cycle %0d got %b want %b", c, vec_m, e); end
      if (c == 5) din = 8'h00;
      if (c == 34) load_m = 1'b0;
      step();
    end
  endtask

  task automatic test_reset_abort();
    logic [4:0] e;
    din = 8'hA5;
    load_m = 1'b1;
    step();
    load_m = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      e = exp8(1'b0, 8'hA5, c);
      checks++;
      if (vec_m !== e) begin errors++; $display("FAIL abort cycle %0d got %b want %b", c, vec_m, e); end
      if (c == 10) rst = 1'b0;
      step();
    end
    checks++; if (vec_m !== 5'b00001) begin errors++; $display("FAIL abort cycle 11 got %b want %b", vec_m, 5'b00001); end
    din = 8'h3C;
    load_m = 1'b1;
    step();
    checks++; if (vec_m !== 5'b00001) begin errors++; $display("FAIL load_in_reset got %b want %b", vec_m, 5'b00001); end
    rst = 1'b1;
    load_m = 1'b0;
    step();
    checks++; if (vec_m !== 5'b00001) begin errors++; $display("FAIL abort_no_done got %b want %b", vec_m, 5'b00001); end
    check_frame8(1'b0, 8'h3C, 1'b0, "after_abort");
  endtask

  task automatic test_div1();
    logic [4:0] e;
    din4 = 4'b1001;
    load_4 = 1'b1;
    checks++; if (vec_4[0] !== 1'b1) begin errors++; $display("FAIL div1 ready_c0 got %b want 1", vec_4[0]); end
    step();
    load_4 = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c <= 4) e = {din4[4 - c], 4'b1100};
      else        e = 5'b00011;
      checks++;
      if (vec_4 !== e) begin errors++; $display("FAIL div1 cycle %0d got %b want %b", c, vec_4, e); end
      step();
    end
  endtask

  initial begin
    test_reset();
    check_frame8(1'b0, 8'hA5, 1'b0, "msb_a5");
    check_frame8(1'b1, 8'h01, 1'b0, "lsb_01");
    test_back_to_back();
    test_reset_abort();
    test_div1();
    check_frame8(1'b0, 8'hA5, 1'b1, "load_ignored");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
